sp_ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of one single-port, byte-write-enable RAM instance (registered read output, one access per cycle, RDWEN=1 write / 0 read).
- Each requester port (A, B) has a valid/ready request channel and a valid/ready read-response channel with a one-entry response holding register.
- Lets two clients, e.g. a cache fill path and a maintenance/debug port, share one BRAM-mapped array without protocol changes on the RAM side.

---
 rtl/sp_ram_arbiter.sv | 157 +++++++++++++++
 tb/tb_sp_ram_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter for two requesters sharing one single-port byte-write RAM.
// Reads return through a per-port one-entry response slot, two cycles after accept.
module sp_ram_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int COL_WIDTH  = 8,
   parameter int DATA_WIDTH = 64,
   localparam int NUM_COL   = DATA_WIDTH / COL_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  A_REQ_VALID,
   output logic                  A_REQ_READY,
   input  logic                  A_REQ_WE,
   input  logic [ADDR_WIDTH-1:0] A_REQ_ADDR,
   input  logic [DATA_WIDTH-1:0] A_REQ_WDATA,
   input  logic [NUM_COL-1:0]    A_REQ_BW,
   output logic                  A_RSP_VALID,
   input  logic                  A_RSP_READY,
   output logic [DATA_WIDTH-1:0] A_RSP_DATA,
   input  logic                  B_REQ_VALID,
   output logic                  B_REQ_READY,
   input  logic                  B_REQ_WE,
   input  logic [ADDR_WIDTH-1:0] B_REQ_ADDR,
   input  logic [DATA_WIDTH-1:0] B_REQ_WDATA,
   input  logic [NUM_COL-1:0]    B_REQ_BW,
   output logic                  B_RSP_VALID,
   input  logic                  B_RSP_READY,
   output logic [DATA_WIDTH-1:0] B_RSP_DATA,
   output logic                  RAM_CE,
   output logic                  RAM_RDWEN,
   output logic [ADDR_WIDTH-1:0] RAM_A,
   output logic [DATA_WIDTH-1:0] RAM_DI,
   output logic [NUM_COL-1:0]    RAM_BW,
   input  logic [DATA_WIDTH-1:0] RAM_DO
);

   if ((DATA_WIDTH % COL_WIDTH) != 32'sd0) begin : g_width_check
      $fatal(1, "DATA_WIDTH must be a multiple of COL_WIDTH");
   end

   typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} port_e;

   port_e                 ptr_q, ptr_d;
   logic                  inflight_q, inflight_d;
   port_e                 inflight_id_q, inflight_id_d;
   logic                  a_slot_q, a_slot_d;
   logic                  b_slot_q, b_slot_d;
   logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
   logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
   logic                  a_elig_s, b_elig_s;
   logic                  a_gnt_s, b_gnt_s;

   // Eligibility and round-robin grant; reset masks grants combinationally.
   always_comb begin
      a_elig_s = A_REQ_VALID && (A_REQ_WE ||
                 (!(inflight_q && (inflight_id_q == PTR_A)) && (!a_slot_q || A_RSP_READY)));
      b_elig_s = B_REQ_VALID && (B_REQ_WE ||
                 (!(inflight_q && (inflight_id_q == PTR_B)) && (!b_slot_q || B_RSP_READY)));
      a_gnt_s  = RST_N && a_elig_s && (!b_elig_s || (ptr_q == PTR_A));
      b_gnt_s  = RST_N && b_elig_s && !a_gnt_s;
   end

   assign A_REQ_READY = a_gnt_s;
   assign B_REQ_READY = b_gnt_s;
   assign A_RSP_VALID = a_slot_q;
   assign B_RSP_VALID = b_slot_q;
   assign A_RSP_DATA  = a_data_q;
   assign B_RSP_DATA  = b_data_q;

   // RAM port mux; byte enables only meaningful on writes.
   always_comb begin
      RAM_CE    = 1'b0;
      RAM_RDWEN = 1'b0;
      RAM_A     = '0;
      RAM_DI    = '0;
      RAM_BW    = '0;
      if (a_gnt_s) begin
         RAM_CE    = 1'b1;
         RAM_RDWEN = A_REQ_WE;
         RAM_A     = A_REQ_ADDR;
         RAM_DI    = A_REQ_WDATA;
         RAM_BW    = A_REQ_WE ? A_REQ_BW : '0;
      end else if (b_gnt_s) begin
         RAM_CE    = 1'b1;
         RAM_RDWEN = B_REQ_WE;
         RAM_A     = B_REQ_ADDR;
         RAM_DI    = B_REQ_WDATA;
         RAM_BW    = B_REQ_WE ? B_REQ_BW : '0;
      end else begin
         RAM_CE    = 1'b0;
      end
   end

   // Pointer, in-flight tracking and response-slot next state.
   always_comb begin
      ptr_d         = ptr_q;
      inflight_d    = 1'b0;
      inflight_id_d = inflight_id_q;
      a_slot_d      = a_slot_q;
      b_slot_d      = b_slot_q;
      a_data_d      = a_data_q;
      b_data_d      = b_data_q;

      if (a_gnt_s) begin
         ptr_d         = PTR_B;
         inflight_d    = !A_REQ_WE;
         inflight_id_d = PTR_A;
      end else if (b_gnt_s) begin
         ptr_d         = PTR_A;
         inflight_d    = !B_REQ_WE;
         inflight_id_d = PTR_B;
      end else begin
         ptr_d         = ptr_q;
      end

      // A capture can coincide with a consume; the refill wins.
      if (inflight_q && (inflight_id_q == PTR_A)) begin
         a_slot_d = 1'b1;
         a_data_d = RAM_DO;
      end else if (a_slot_q && A_RSP_READY) begin
         a_slot_d = 1'b0;
      end else begin
         a_slot_d = a_slot_q;
      end

      if (inflight_q && (inflight_id_q == PTR_B)) begin
         b_slot_d = 1'b1;
         b_data_d = RAM_DO;
      end else if (b_slot_q && B_RSP_READY) begin
         b_slot_d = 1'b0;
      end else begin
         b_slot_d = b_slot_q;
      end
   end

   // State registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr_q         <= PTR_A;
         inflight_q    <= 1'b0;
         inflight_id_q <= PTR_A;
         a_slot_q      <= 1'b0;
         b_slot_q      <= 1'b0;
         a_data_q      <= '0;
         b_data_q      <= '0;
      end else begin
         ptr_q         <= ptr_d;
         inflight_q    <= inflight_d;
         inflight_id_q <= inflight_id_d;
         a_slot_q      <= a_slot_d;
         b_slot_q      <= b_slot_d;
         a_data_q      <= a_data_d;
         b_data_q      <= b_data_d;
      end
   end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: directed scenarios plus random traffic, checked by a
// port-level reference model feeding per-port expected-response queues.
module tb_sp_ram_arbiter;

   typedef struct packed {
      logic [63:0] data;
      int          due;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [9:0]  req_addr  [2];
   logic [63:0] req_wdata [2];
   logic [7:0]  req_bw    [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [63:0] rsp_data  [2];
   logic        RAM_CE, RAM_RDWEN;
   logic [9:0]  RAM_A;
   logic [63:0] RAM_DI;
   logic [7:0]  RAM_BW;
   logic [63:0] ram_do = 64'd0;

   logic [63:0] ram_mem [1024] = '{default: 64'd0};
   logic [63:0] ref_mem [1024] = '{default: 64'd0};
   exp_t        q [2][$];
   bit          ptr_m = 1'b0;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   sp_ram_arbiter dut (
      .CLK(CLK), .RST_N(RST_N),
      .A_REQ_VALID(req_valid[0]), .A_REQ_READY(req_ready[0]), .A_REQ_WE(req_we[0]),
      .A_REQ_ADDR(req_addr[0]), .A_REQ_WDATA(req_wdata[0]), .A_REQ_BW(req_bw[0]),
      .A_RSP_VALID(rsp_valid[0]), .A_RSP_READY(rsp_ready[0]), .A_RSP_DATA(rsp_data[0]),
      .B_REQ_VALID(req_valid[1]), .B_REQ_READY(req_ready[1]), .B_REQ_WE(req_we[1]),
      .B_REQ_ADDR(req_addr[1]), .B_REQ_WDATA(req_wdata[1]), .B_REQ_BW(req_bw[1]),
      .B_RSP_VALID(rsp_valid[1]), .B_RSP_READY(rsp_ready[1]), .B_RSP_DATA(rsp_data[1]),
      .RAM_CE(RAM_CE), .RAM_RDWEN(RAM_RDWEN), .RAM_A(RAM_A), .RAM_DI(RAM_DI),
      .RAM_BW(RAM_BW), .RAM_DO(ram_do)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Behavioural single-port RAM with registered read data.
   always @(posedge CLK) begin
      if (RAM_CE) begin
         if (RAM_RDWEN) begin
            for (int c = 0; c < 8; c++)
               if (RAM_BW[c]) ram_mem[RAM_A][c*8 +: 8] <= RAM_DI[c*8 +: 8];
         end else begin
            ram_do <= ram_mem[RAM_A];
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: expected grants and RAM drive, memory image, queued responses.
   always @(negedge CLK) begin : model
      bit el [2];
      bit g  [2];
      int k;
      if (!RST_N) begin
         chk("rst_a_ready", req_ready[0], 1'b0);
         chk("rst_b_ready", req_ready[1], 1'b0);
         chk("rst_ram_ce", RAM_CE, 1'b0);
         q[0].delete();
         q[1].delete();
         ptr_m = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++)
            el[i] = req_valid[i] && (req_we[i] || q[i].size() == 0 ||
                    (q[i].size() == 1 && cyc >= q[i][0].due && rsp_ready[i]));
         g[0] = el[0] && (!el[1] || ptr_m == 1'b0);
         g[1] = el[1] && !g[0];
         chk("a_ready", req_ready[0], g[0]);
         chk("b_ready", req_ready[1], g[1]);
         chk("ram_ce", RAM_CE, g[0] || g[1]);
         if (g[0] || g[1]) begin
            k = g[1] ? 1 : 0;
            chk("ram_a", RAM_A, req_addr[k]);
            chk("ram_rdwen", RAM_RDWEN, req_we[k]);
            chk("ram_di", RAM_DI, req_wdata[k]);
            chk("ram_bw", RAM_BW, req_we[k] ? req_bw[k] : 8'h00);
            ptr_m = (k == 0);
            if (req_we[k]) begin
               for (int c = 0; c < 8; c++)
                  if (req_bw[k][c]) ref_mem[req_addr[k]][c*8 +: 8] = req_wdata[k][c*8 +: 8];
            end else begin
               q[k].push_back('{data: ref_mem[req_addr[k]], due: cyc + 2});
            end
         end else begin
            chk("idle_bus", {RAM_RDWEN, RAM_BW, RAM_A}, 64'd0);
            chk("idle_di", RAM_DI, 64'd0);
         end
      end
   end

   // Response monitor: pops expected entries as the DUT presents and hands off data.
   always @(negedge CLK) begin : monitor
      #1;
      for (int i = 0; i < 2; i++) begin
         if (!RST_N) begin
            chk("rst_rsp_valid", rsp_valid[i], 1'b0);
         end else begin
            if (q[i].size() > 0 && q[i][0].due == cyc)
               chk("rsp_latency", rsp_valid[i], 1'b1);
            if (rsp_valid[i]) begin
               chk("rsp_expected", (q[i].size() > 0 && cyc >= q[i][0].due), 1'b1);
               if (q[i].size() > 0 && rsp_ready[i]) begin
                  chk("rsp_data", rsp_data[i], q[i][0].data);
                  void'(q[i].pop_front());
               end
            end
         end
      end
   end

   task automatic issue(input int p, input bit we, input logic [9:0] a,
                        input logic [63:0] d, input logic [7:0] bw);
      int n = 0;
      req_valid[p] = 1'b1; req_we[p] = we; req_addr[p] = a; req_wdata[p] = d; req_bw[p] = bw;
      do begin
         @(negedge CLK);
         n++;
      end while (!req_ready[p] && n < 30);
      chk("issue_accept", req_ready[p], 1'b1);
      @(posedge CLK); #1;
      req_valid[p] = 1'b0;
   endtask

   task automatic wait_rsp(input int p, input logic [63:0] exp, input string nm);
      @(negedge CLK);
      chk({nm, "_early"}, rsp_valid[p], 1'b0);
      @(negedge CLK);
      chk({nm, "_valid"}, rsp_valid[p], 1'b1);
      chk({nm, "_data"}, rsp_data[p], exp);
      @(posedge CLK); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ga, gb, ce;
      for (int p = 0; p < 2; p++) begin
         req_valid[p] = 1'b0; req_we[p] = 1'b0; req_addr[p] = 10'd0;
         req_wdata[p] = 64'd0; req_bw[p] = 8'd0; rsp_ready[p] = 1'b1;
      end
      repeat (3) @(posedge CLK);
      #1 RST_N = 1'b1;

      // Reset in the cycle after a read accept drops the read.
      issue(0, 1'b0, 10'h020, 64'd0, 8'h00);
      RST_N = 1'b0;
      for (int p = 0; p < 2; p++) begin
         req_valid[p] = 1'b1; req_we[p] = 1'b1; req_addr[p] = 10'h030 + 10'(p);
         req_wdata[p] = 64'h0123_4567_89AB_CDEF; req_bw[p] = 8'hFF;
      end
      repeat (3) begin
         @(negedge CLK);
         chk("rst_hold_ce", RAM_CE, 1'b0);
         chk("rst_hold_a_rsp", rsp_valid[0], 1'b0);
         @(posedge CLK); #1;
      end
      RST_N = 1'b1;
      @(negedge CLK);
      chk("post_rst_a_first", req_ready[0], 1'b1);
      chk("post_rst_b_wait", req_ready[1], 1'b0);
      @(posedge CLK); #1;
      req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         chk("post_rst_no_rsp", rsp_valid[0], 1'b0);
      end
      @(posedge CLK); #1;

      // Single write then read.
      issue(0, 1'b1, 10'h010, 64'h1122_3344_5566_7788, 8'hFF);
      issue(0, 1'b0, 10'h010, 64'd0, 8'h00);
      wait_rsp(0, 64'h1122_3344_5566_7788, "single_rd");

      // Byte-enable write.
      issue(1, 1'b1, 10'h003, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      issue(1, 1'b1, 10'h003, 64'h0000_0000_0000_0000, 8'h0F);
      issue(1, 1'b0, 10'h003, 64'd0, 8'h00);
      wait_rsp(1, 64'hFFFF_FFFF_0000_0000, "byte_wr");

      // Both ports streaming writes share the RAM evenly.
      ga = 0; gb = 0; ce = 0;
      for (int i = 0; i < 8; i++) begin
         for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b1; req_we[p] = 1'b1; req_bw[p] = 8'hFF;
            req_addr[p] = 10'h040 + 10'(2 * i + p); req_wdata[p] = {$urandom, $urandom};
         end
         @(negedge CLK);
         ga += int'(req_ready[0]); gb += int'(req_ready[1]); ce += int'(RAM_CE);
         @(posedge CLK); #1;
      end
      req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      chk("cont_a_grants", ga, 4);
      chk("cont_b_grants", gb, 4);
      chk("cont_ce_cycles", ce, 8);

      // Response backpressure blocks A's second read; B writes continue.
      issue(1, 1'b1, 10'h005, 64'hCAFE_F00D_1234_5678, 8'hFF);
      rsp_ready[0] = 1'b0;
      issue(0, 1'b0, 10'h005, 64'd0, 8'h00);
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'h005;
      for (int i = 0; i < 5; i++) begin
         req_valid[1] = 1'b1; req_we[1] = 1'b1; req_bw[1] = 8'hFF;
         req_addr[1] = 10'h080 + 10'(i); req_wdata[1] = {$urandom, $urandom};
         @(negedge CLK);
         chk("bp_a_blocked", req_ready[0], 1'b0);
         chk("bp_b_granted", req_ready[1], 1'b1);
         if (i > 0) begin
            chk("bp_hold_valid", rsp_valid[0], 1'b1);
            chk("bp_hold_data", rsp_data[0], 64'hCAFE_F00D_1234_5678);
         end
         @(posedge CLK); #1;
      end
      req_valid[1] = 1'b0;
      rsp_ready[0] = 1'b1;
      issue(0, 1'b0, 10'h005, 64'd0, 8'h00);
      repeat (3) @(posedge CLK);
      #1;

      // Read-after-write, next cycle and same cycle.
      issue(0, 1'b1, 10'h007, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
      issue(1, 1'b0, 10'h007, 64'd0, 8'h00);
      wait_rsp(1, 64'hAAAA_AAAA_AAAA_AAAA, "raw_next");
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 10'h007;
      req_wdata[0] = 64'h5555_5555_5555_5555; req_bw[0] = 8'hFF;
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 10'h007;
      @(negedge CLK);
      chk("raw_same_a_first", req_ready[0], 1'b1);
      chk("raw_same_b_wait", req_ready[1], 1'b0);
      @(posedge CLK); #1;
      req_valid[0] = 1'b0;
      @(negedge CLK);
      chk("raw_same_b_next", req_ready[1], 1'b1);
      @(posedge CLK); #1;
      req_valid[1] = 1'b0;
      wait_rsp(1, 64'h5555_5555_5555_5555, "raw_same");

      // Random traffic over a small address window.
      for (int i = 0; i < 3000; i++) begin
         for (int p = 0; p < 2; p++) begin
            req_valid[p] = ($urandom_range(0, 3) != 0);
            req_we[p]    = 1'($urandom_range(0, 1));
            req_addr[p]  = 10'($urandom_range(0, 15));
            req_wdata[p] = {$urandom, $urandom};
            req_bw[p]    = 8'($urandom);
            rsp_ready[p] = ($urandom_range(0, 3) != 0);
         end
         @(posedge CLK); #1;
      end

      for (int p = 0; p < 2; p++) begin
         req_valid[p] = 1'b0; rsp_ready[p] = 1'b1;
      end
      repeat (6) @(posedge CLK);
      @(negedge CLK); #2;
      chk("drain_a", q[0].size(), 0);
      chk("drain_b", q[1].size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
